mem_access_ctrl: RTL and testbench

- Sequencer between the CPU load/store path and the single-port synchronous word RAM.
- RAM is 512 x 32, with read/write strobes and registered read data appearing one cycle after the read strobe.
- Accepts one request at a time over a ready/valid handshake and drives RAM strobes, address and write data.
- Captures read data; performs byte-enable read-modify-write (RMW) for partial-word stores.

---
 rtl/mem_access_ctrl_pkg.sv | 20 ++
 rtl/mem_access_ctrl_byte_merge.sv | 21 ++
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the CPU-to-RAM access sequencer.
package mem_access_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BE_W_DEF   = DATA_W_DEF / 8;

  localparam logic [BE_W_DEF-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_CAP  = 3'd2,
    RMW_RD  = 3'd3,
    RMW_MRG = 3'd4,
    WR      = 3'd5,
    ACK     = 3'd6
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take the new word, others keep the old word.
module byte_merge
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_word;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) merged_c[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-request sequencer between the CPU load/store path and a 1-cycle-latency word RAM.
// Build option MEM_ACCESS_CTRL_RMW_EN enables read-modify-write for partial-word stores.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [BE_W-1:0] BE_FULL = '1;

  state_t            state, state_n;
  logic              ready_n, done_n, read_n, write_n;
  logic [DATA_W-1:0] rdata_n, wdata_n;
  logic [ADDR_W-1:0] addr_n;

`ifdef MEM_ACCESS_CTRL_RMW_EN
  logic [BE_W-1:0]   lat_be, lat_be_n;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_n;
  logic [DATA_W-1:0] merged_c;

  byte_merge #(.DATA_W(DATA_W)) u_byte_merge (
    .old_word (ram_rdata),
    .new_word (lat_wdata),
    .be       (lat_be),
    .merged_c (merged_c)
  );
`endif

  // State and registered outputs; async reset kills any strobe in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_ready <= 1'b1;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef MEM_ACCESS_CTRL_RMW_EN
      lat_be    <= '0;
      lat_wdata <= '0;
`endif
    end else begin
      state     <= state_n;
      cpu_ready <= ready_n;
      cpu_done  <= done_n;
      cpu_rdata <= rdata_n;
      ram_read  <= read_n;
      ram_write <= write_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
`ifdef MEM_ACCESS_CTRL_RMW_EN
      lat_be    <= lat_be_n;
      lat_wdata <= lat_wdata_n;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    ready_n = cpu_ready;
    done_n  = 1'b0;
    rdata_n = cpu_rdata;
    read_n  = 1'b0;
    write_n = 1'b0;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
`ifdef MEM_ACCESS_CTRL_RMW_EN
    lat_be_n    = lat_be;
    lat_wdata_n = lat_wdata;
`endif

    case (state)
      IDLE: begin
        if (cpu_req) begin
          ready_n = 1'b0;
          addr_n  = cpu_addr;
          if (!cpu_we) begin
            read_n  = 1'b1;
            state_n = RD;
          end else if (cpu_be == '0) begin
            state_n = ACK;
`ifdef MEM_ACCESS_CTRL_RMW_EN
          end else if (cpu_be != BE_FULL) begin
            read_n      = 1'b1;
            lat_be_n    = cpu_be;
            lat_wdata_n = cpu_wdata;
            state_n     = RMW_RD;
`endif
          end else begin
            wdata_n = cpu_wdata;
            write_n = 1'b1;
            state_n = WR;
          end
        end
      end
      RD:      state_n = RD_CAP;
      RD_CAP: begin
        rdata_n = ram_rdata;
        done_n  = 1'b1;
        ready_n = 1'b1;
        state_n = IDLE;
      end
`ifdef MEM_ACCESS_CTRL_RMW_EN
      RMW_RD:  state_n = RMW_MRG;
      RMW_MRG: begin
        wdata_n = merged_c;
        write_n = 1'b1;
        state_n = WR;
      end
`endif
      WR, ACK: begin
        done_n  = 1'b1;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: begin
        ready_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural 512x32 registered-read RAM.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_be;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_done;
  logic [31:0] cpu_rdata;
  logic        ram_read, ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [512];
  logic [31:0] done_q[$];
  logic        overlap = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  mem_access_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_read && ram_write) overlap <= 1'b1;
    if (cpu_done) done_q.push_back(cpu_rdata);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request: wait for ready, accept, then count cycles to done and strobe activity.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [8:0] addr,
                        input logic [31:0] wd, output int lat, output int nrd,
                        output int nwr, output int rd_at, output int wr_at);
    int n;
    lat = 0; nrd = 0; nwr = 0; rd_at = -1; wr_at = -1; n = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    while (!cpu_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) check("ready_timeout", 32'(cpu_ready), 32'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_read) begin nrd++; if (rd_at < 0) rd_at = c; end
      if (ram_write) begin nwr++; if (wr_at < 0) wr_at = c; end
      if (cpu_done) begin lat = c; break; end
    end
    if (lat == 0) check("done_timeout", 32'(cpu_done), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(cpu_done), 32'd0);
  endtask

  initial begin
    int lat, nrd, nwr, rd_at, wr_at, n;
    int acc [3];
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done",  32'(cpu_done),  32'd0);
    check("rst_rdata", cpu_rdata,      32'd0);
    check("rst_read",  32'(ram_read),  32'd0);
    check("rst_write", 32'(ram_write), 32'd0);
    check("rst_addr",  32'(ram_addr),  32'd0);
    check("rst_wdata", ram_wdata,      32'd0);
    reset_n = 1'b1;

    // Reset in the middle of a store must suppress the write.
    do_req(1'b1, 4'hF, 9'h010, 32'h01020304, lat, nrd, nwr, rd_at, wr_at);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 9'h010; cpu_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    check("midrst_write_hi", 32'(ram_write), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_write_lo", 32'(ram_write), 32'd0);
    check("midrst_ready", 32'(cpu_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_mem", mem[9'h010], 32'h01020304);
    check("midrst_ready_after", 32'(cpu_ready), 32'd1);

    // Full store then load.
    do_req(1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF, lat, nrd, nwr, rd_at, wr_at);
    check("st_lat", 32'(lat), 32'd2);
    check("st_nrd", 32'(nrd), 32'd0);
    check("st_nwr", 32'(nwr), 32'd1);
    check("st_mem", mem[9'h1A5], 32'hDEADBEEF);
    do_req(1'b0, 4'h0, 9'h1A5, 32'h0, lat, nrd, nwr, rd_at, wr_at);
    check("ld_lat", 32'(lat), 32'd3);
    check("ld_nrd", 32'(nrd), 32'd1);
    check("ld_nwr", 32'(nwr), 32'd0);
    check("ld_rdata", cpu_rdata, 32'hDEADBEEF);

    // Partial store.
    do_req(1'b1, 4'hF, 9'h007, 32'h11223344, lat, nrd, nwr, rd_at, wr_at);
    do_req(1'b1, 4'b0101, 9'h007, 32'hAABBCCDD, lat, nrd, nwr, rd_at, wr_at);
`ifdef MEM_ACCESS_CTRL_RMW_EN
    check("rmw_lat", 32'(lat), 32'd4);
    check("rmw_nrd", 32'(nrd), 32'd1);
    check("rmw_gap", 32'(wr_at - rd_at), 32'd2);
    check("rmw_mem", mem[9'h007], 32'h11BB33DD);
`else
    check("part_lat", 32'(lat), 32'd2);
    check("part_nrd", 32'(nrd), 32'd0);
    check("part_mem", mem[9'h007], 32'hAABBCCDD);
`endif
    check("part_nwr", 32'(nwr), 32'd1);
    check("part_rdata_kept", cpu_rdata, 32'hDEADBEEF);

    // Null store.
    do_req(1'b1, 4'hF, 9'h003, 32'h33333333, lat, nrd, nwr, rd_at, wr_at);
    do_req(1'b1, 4'h0, 9'h003, 32'h99999999, lat, nrd, nwr, rd_at, wr_at);
    check("null_lat", 32'(lat), 32'd2);
    check("null_nrd", 32'(nrd), 32'd0);
    check("null_nwr", 32'(nwr), 32'd0);
    check("null_mem", mem[9'h003], 32'h33333333);

    // Back-to-back with cpu_req held high.
    do_req(1'b1, 4'hF, 9'h000, 32'h0BADF00D, lat, nrd, nwr, rd_at, wr_at);
    do_req(1'b1, 4'hF, 9'h1FF, 32'h55AA33CC, lat, nrd, nwr, rd_at, wr_at);
    @(negedge clk);
    done_q.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = 9'h000; cpu_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!cpu_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!cpu_ready) check("b2b_ready_timeout", 32'(cpu_ready), 32'd1);
      @(posedge clk);
      #1;
      acc[k] = cyc;
      if (k == 0) begin
        cpu_addr = 9'h1FF;
      end else if (k == 1) begin
        cpu_we = 1'b1; cpu_be = 4'hF; cpu_wdata = 32'h12345678;
      end else begin
        cpu_req = 1'b0;
      end
    end
    n = 0;
    while (done_q.size() < 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("b2b_ndone", 32'(done_q.size()), 32'd3);
    if (done_q.size() >= 3) begin
      check("b2b_rd0", done_q[0], 32'h0BADF00D);
      check("b2b_rd1", done_q[1], 32'h55AA33CC);
      check("b2b_rd_after_st", done_q[2], 32'h55AA33CC);
    end
    check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
    check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);
    check("b2b_mem", mem[9'h1FF], 32'h12345678);
    check("b2b_rdata_final", cpu_rdata, 32'h55AA33CC);
    check("no_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
